// File: rtl/ysyx_220066_lsu.sv
// ----------------------------------------------------------------------------
// ysyx_220066_lsu
// Load/store unit between the CPU execute stage and a valid/ready data bus.
// Each CPU request is run through a small request/response FSM:
//   IDLE -> ADDR (bus address phase) -> WAIT (data/ack phase) -> RESP -> IDLE
// The unit aligns byte lanes, builds write strobes, and sign/zero-extends
// loads. It also flags illegal ops and bus errors, and aborts a transaction
// that stalls for TIMEOUT cycles.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   req_*          CPU request (valid/ready, wr, byte address, memop, wdata)
//   rsp_*          one-cycle response pulse with extended load data and error
//   bus_valid/ready/we/addr/wdata/wstrb   bus request channel
//   bus_rvalid/rdata/rerr                 bus read data / write ack channel
//
// Optional feature (macro LSU_MISALIGN_CHECK_EN)
//   defined   : misaligned accesses return an error without touching the bus
//   undefined : the low address bits are force-aligned to the access size
// ----------------------------------------------------------------------------
module ysyx_220066_lsu #(
  parameter int XLEN    = 64,
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [2:0]          req_memop,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                rsp_valid,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic                rsp_err,
  output logic                bus_valid,
  input  logic                bus_ready,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [XLEN-1:0]     bus_wdata,
  output logic [XLEN/8-1:0]   bus_wstrb,
  input  logic                bus_rvalid,
  input  logic [XLEN-1:0]     bus_rdata,
  input  logic                bus_rerr
);

  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int CNT_W  = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, RESP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               lat_wr;
  logic [1:0]         lat_size;
  logic               lat_unsigned;
  logic [OFF_W-1:0]   lat_off;

  // Request decode, evaluated on the raw request fields in IDLE.
  logic [1:0]         size;
  logic [3:0]         nbytes;
  logic [OFF_W-1:0]   off;
  logic [OFF_W-1:0]   off_mask;
  logic [OFF_W-1:0]   off_eff;
  logic               misalign;
  logic               illegal;
  logic [STRB_W-1:0]  strb_base;
  logic [STRB_W-1:0]  strb;
  logic [XLEN-1:0]    byte_mask;
  logic [XLEN-1:0]    wdata;

  always_comb begin
    size      = req_memop[1:0];
    nbytes    = 4'd1 << size;
    off       = req_addr[OFF_W-1:0];
    off_mask  = OFF_W'((4'd1 << size) - 4'd1);
`ifdef LSU_MISALIGN_CHECK_EN
    misalign  = (off & off_mask) != '0;
    off_eff   = off;
`else
    misalign  = 1'b0;
    off_eff   = off & ~off_mask;
`endif
    illegal   = (req_wr && req_memop[2]) || ((XLEN == 32) && (size == 2'd3));
    strb_base = STRB_W'((16'd1 << nbytes) - 16'd1);
    strb      = strb_base << off_eff;
    byte_mask = '0;
    for (int i = 0; i < STRB_W; i++) begin
      byte_mask[8*i +: 8] = {8{strb[i]}};
    end
    // Bytes outside the strobe are driven 0 rather than left as shifted junk.
    wdata     = (req_wdata << {off_eff, 3'b000}) & byte_mask;
  end

  // Load extension uses the latched size/offset against live bus_rdata.
  logic [XLEN-1:0]    raw;
  logic [XLEN-1:0]    lmask;
  logic               sbit;
  logic [XLEN-1:0]    load_data;

  always_comb begin
    raw = bus_rdata >> {lat_off, 3'b000};
    case (lat_size)
      2'd0:    begin lmask = XLEN'(8'hFF);          sbit = raw[7];      end
      2'd1:    begin lmask = XLEN'(16'hFFFF);       sbit = raw[15];     end
      2'd2:    begin lmask = XLEN'(32'hFFFF_FFFF);  sbit = raw[31];     end
      default: begin lmask = '1;                    sbit = raw[XLEN-1]; end
    endcase
    load_data = (raw & lmask) | ((sbit && !lat_unsigned) ? ~lmask : '0);
  end

  // rsp_valid is registered out of RESP, so the abort is taken one cycle
  // before the count hits TIMEOUT; the error pulse then lands exactly
  // TIMEOUT clocks after the accept edge.
  logic timeout_hit;
  assign timeout_hit = (32'(cnt) + 32'd2) >= 32'(TIMEOUT);

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_wr       <= 1'b0;
      lat_size     <= 2'd0;
      lat_unsigned <= 1'b0;
      lat_off      <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      bus_valid    <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      bus_wstrb    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            cnt          <= '0;
            lat_wr       <= req_wr;
            lat_size     <= size;
            lat_unsigned <= req_memop[2];
            lat_off      <= off_eff;
            if (illegal || misalign) begin
              state     <= RESP;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state     <= ADDR;
              bus_valid <= 1'b1;
              bus_we    <= req_wr;
              bus_addr  <= req_addr & ~ADDR_W'(STRB_W - 1);
              bus_wdata <= wdata;
              bus_wstrb <= strb;
            end
          end
        end
        ADDR: begin
          cnt <= cnt + 1'b1;
          if (timeout_hit) begin
            state     <= RESP;
            bus_valid <= 1'b0;
            bus_we    <= 1'b0;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else if (bus_ready) begin
            state     <= WAIT;
            bus_valid <= 1'b0;
            bus_we    <= 1'b0;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (timeout_hit) begin
            state     <= RESP;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else if (bus_rvalid) begin
            state     <= RESP;
            rsp_err   <= bus_rerr;
            rsp_rdata <= lat_wr ? '0 : load_data;
          end
        end
        RESP: begin
          rsp_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
